// File: rtl/adder_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_ctrl_if
// Description : Bus bundle between the adder-sharing controller, its
//               requesting clients, the shared adder and the response consumer.
//               master = client/adder/consumer side, slave = controller.
// Revision    : 1.0  initial release
// ============================================================================
interface adder_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 4
);
  // Requester side
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   ack;
  // Shared adder side
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_en;
  logic [W-1:0]      add_sum;
  logic              add_ovf;
  // Response side
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf;
  // Status
  logic              busy;

  modport master (
    output req, req_a, req_b, add_sum, add_ovf, rsp_ready,
    input  ack, add_a, add_b, add_en, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );

  modport slave (
    input  req, req_a, req_b, add_sum, add_ovf, rsp_ready,
    output ack, add_a, add_b, add_en, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_ctrl
// Description : Time-shares one registered adder (1-cycle latency, enable
//               gated) among NREQ requesters. Round-robin arbitration,
//               operand muxing, adder sequencing and a held response tagged
//               with the owning requester ID.
//               Optional macro ADDER_SHARE_OVF_TRAP_EN adds an overflow trap
//               pulse (ovf_trap_o) and a saturating overflow counter
//               (ovf_cnt_o).
// Revision    : 1.0  initial release
// ============================================================================
module adder_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  adder_share_ctrl_if.slave bus_if
`ifdef ADDER_SHARE_OVF_TRAP_EN
  ,
  output logic              ovf_trap_o,
  output logic [7:0]        ovf_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  gnt_q;
  logic [NREQ-1:0] ack_q;
  logic [W-1:0]    add_a_q;
  logic [W-1:0]    add_b_q;
  logic            add_en_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_ovf_q;
  logic            busy_q;

  logic [W-1:0]    req_a_arr [NREQ];
  logic [W-1:0]    req_b_arr [NREQ];
  logic [IDW-1:0]  win_idx_d;
  logic            win_any_d;
  logic [IDW-1:0]  cand_idx;
  int unsigned     cand_sum;

  // Unpack the flattened operand buses so the winner can be selected by index
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_a_arr[i] = bus_if.req_a[i*W +: W];
    assign req_b_arr[i] = bus_if.req_b[i*W +: W];
  end

  // Round-robin search: first requesting index at or after rr_ptr, wrapping
  always_comb begin
    win_any_d = 1'b0;
    win_idx_d = '0;
    cand_sum  = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = 32'(rr_ptr_q) + 32'(k);
      if (cand_sum >= 32'(NREQ)) begin
        cand_sum = cand_sum - 32'(NREQ);
      end
      cand_idx = IDW'(cand_sum);
      if (!win_any_d && bus_if.req[cand_idx]) begin
        win_any_d = 1'b1;
        win_idx_d = cand_idx;
      end
    end
  end

  // Controller FSM; every bus output is a register loaded on state transitions
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Outputs for ISSUE are loaded here so they are live for that whole cycle
          if (win_any_d) begin
            gnt_q    <= win_idx_d;
            ack_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_d;
            add_a_q  <= req_a_arr[win_idx_d];
            add_b_q  <= req_b_arr[win_idx_d];
            add_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Adder samples its operands on this edge; drop enable so its
          // output is held until captured
          ack_q    <= '0;
          add_en_q <= 1'b0;
          rr_ptr_q <= (gnt_q == IDW'(NREQ-1)) ? '0 : gnt_q + 1'b1;
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_sum_q   <= bus_if.add_sum;
          rsp_ovf_q   <= bus_if.add_ovf;
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_if.ack       = ack_q;
  assign bus_if.add_a     = add_a_q;
  assign bus_if.add_b     = add_b_q;
  assign bus_if.add_en    = add_en_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_id    = rsp_id_q;
  assign bus_if.rsp_sum   = rsp_sum_q;
  assign bus_if.rsp_ovf   = rsp_ovf_q;
  assign bus_if.busy      = busy_q;

`ifdef ADDER_SHARE_OVF_TRAP_EN
  logic [7:0] ovf_cnt_q;

  // Saturating count of overflowing results, counted as they are captured
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt_q <= '0;
    end else if ((state_q == S_CAPTURE) && bus_if.add_ovf && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  // Trap is visible during the CAPTURE cycle itself, alongside the adder result
  assign ovf_trap_o = (state_q == S_CAPTURE) && bus_if.add_ovf;
  assign ovf_cnt_o  = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_ctrl
// Description : Self-checking bench for adder_share_ctrl with a registered
//               enable-gated 4-bit adder model on the shared datapath.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adder_share_ctrl;

  logic clk;
  logic rst;

  adder_share_ctrl_if #(.NREQ(4), .IDW(2), .W(4)) bus ();

`ifdef ADDER_SHARE_OVF_TRAP_EN
  logic       ovf_trap;
  logic [7:0] ovf_cnt;
`endif

  adder_share_ctrl #(.NREQ(4), .IDW(2), .W(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
`ifdef ADDER_SHARE_OVF_TRAP_EN
    ,
    .ovf_trap_o (ovf_trap),
    .ovf_cnt_o  (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: registered, 1-cycle latency, only loads when enabled
  always_ff @(posedge clk) begin
    if (bus.add_en) begin
      {bus.add_ovf, bus.add_sum} <= bus.add_a + bus.add_b;
    end
  end

  int checks;
  int errors;
  int exp_ovf_cnt;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    logic [3:0]  sum;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack"},    32'(bus.ack), 0);
    chk({tag, "_add_en"}, 32'(bus.add_en), 0);
    chk({tag, "_add_ab"}, 32'({bus.add_a, bus.add_b}), 0);
    chk({tag, "_valid"},  32'(bus.rsp_valid), 0);
    chk({tag, "_rsp"},    32'({bus.rsp_id, bus.rsp_sum, bus.rsp_ovf}), 0);
    chk({tag, "_busy"},   32'(bus.busy), 0);
`ifdef ADDER_SHARE_OVF_TRAP_EN
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 0);
`endif
  endtask

  // One full transaction from IDLE with the consumer always ready
  task automatic run_txn(input vec_t v, input int n);
    logic [3:0] ea;
    logic [3:0] eb;
    string      tag;
    tag = $sformatf("v%0d", n);
    ea  = 4'(v.a >> (4 * v.id));
    eb  = 4'(v.b >> (4 * v.id));
    bus.req   = v.req;
    bus.req_a = v.a;
    bus.req_b = v.b;
    tick();  // ISSUE
    chk({tag, "_ack"},    32'(bus.ack), 32'(4'b0001 << v.id));
    chk({tag, "_add_en"}, 32'(bus.add_en), 1);
    chk({tag, "_add_a"},  32'(bus.add_a), 32'(ea));
    chk({tag, "_add_b"},  32'(bus.add_b), 32'(eb));
    chk({tag, "_busy"},   32'(bus.busy), 1);
    // Operands scrambled after the ack must not reach the result
    bus.req   = 4'b0000;
    bus.req_a = ~v.a;
    bus.req_b = ~v.b;
    tick();  // CAPTURE
    chk({tag, "_cap_quiet"}, 32'({bus.ack, bus.add_en, bus.rsp_valid}), 0);
`ifdef ADDER_SHARE_OVF_TRAP_EN
    chk({tag, "_trap"}, 32'(ovf_trap), 32'(v.ovf));
    if (v.ovf) exp_ovf_cnt++;
`endif
    tick();  // RESP
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_id"},    32'(bus.rsp_id), 32'(v.id));
    chk({tag, "_sum"},   32'(bus.rsp_sum), 32'(v.sum));
    chk({tag, "_ovf"},   32'(bus.rsp_ovf), 32'(v.ovf));
`ifdef ADDER_SHARE_OVF_TRAP_EN
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf_cnt));
`endif
    tick();  // back in IDLE
    chk({tag, "_done"}, 32'({bus.rsp_valid, bus.busy}), 0);
  endtask

  initial begin
    int         ngr;
    int         last_c;
    int         order[6];
    int         cnt[4];
    vec_t       rv;

    checks = 0;
    errors = 0;
    exp_ovf_cnt = 0;
    order = '{0, 1, 2, 3, 0, 1};

    // Round-robin pointer evolution through the table: 0->1->3->0->1->2->1->2->2
    vecs[0] = '{4'b0001, 16'hABC3, 16'h9874, 0, 4'h7, 1'b0};
    vecs[1] = '{4'b0100, 16'h1923, 16'h4856, 2, 4'h1, 1'b1};
    vecs[2] = '{4'b1000, 16'hF000, 16'hF111, 3, 4'hE, 1'b1};
    vecs[3] = '{4'b1001, 16'h5001, 16'h5002, 0, 4'h3, 1'b0};
    vecs[4] = '{4'b1111, 16'h1270, 16'h3390, 1, 4'h0, 1'b1};
    vecs[5] = '{4'b0011, 16'h0080, 16'h0070, 0, 4'h0, 1'b0};
    vecs[6] = '{4'b1010, 16'h2080, 16'h3070, 1, 4'hF, 1'b0};
    vecs[7] = '{4'b0010, 16'h00A0, 16'h0060, 1, 4'h0, 1'b1};

    rst = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
    end

    // Backpressure: response held, no new grant while a request waits (ptr=2)
    bus.rsp_ready = 1'b0;
    bus.req   = 4'b0100;
    bus.req_a = 16'h0600;
    bus.req_b = 16'h0500;
    tick();
    chk("bp_ack", 32'(bus.ack), 32'(4'b0100));
    bus.req   = 4'b0001;
    bus.req_a = 16'h0002;
    bus.req_b = 16'h0002;
    tick();
    tick();
    chk("bp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_rsp",   32'({bus.rsp_id, bus.rsp_sum, bus.rsp_ovf}), 32'({2'd2, 4'hB, 1'b0}));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_rsp",   32'({bus.rsp_id, bus.rsp_sum, bus.rsp_ovf}), 32'({2'd2, 4'hB, 1'b0}));
      chk("bp_hold_quiet", 32'({bus.ack, bus.add_en}), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'({bus.rsp_valid, bus.ack}), 0);
    tick();
    chk("bp_next_ack", 32'(bus.ack), 32'(4'b0001));
    bus.req = 4'b0000;
    tick();
    tick();
    chk("bp_next_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_ovf}),
        32'({1'b1, 2'd0, 4'h4, 1'b0}));
    tick();

    // Fresh reset so the rotation starts at requester 0
    rst = 1'b1;
    exp_ovf_cnt = 0;
    tick();
    check_reset_state("rst1");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fairness: all requesting, each re-raises 2 cycles after its ack
    bus.req = 4'b1111;
    bus.req_a = 16'h4321;
    bus.req_b = 16'h1111;
    cnt = '{0, 0, 0, 0};
    ngr = 0;
    last_c = 0;
    for (int c = 0; c < 80 && ngr < 6; c++) begin
      tick();
      if (bus.ack != 4'b0000) begin
        chk("fair_order", 32'(bus.ack), 32'(4'b0001 << order[ngr]));
        if (ngr > 0) chk("fair_gap", 32'(c - last_c), 4);
        last_c = c;
        ngr++;
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          bus.req[i] = 1'b0;
          cnt[i] = 2;
        end else if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) bus.req[i] = 1'b1;
        end
      end
    end
    chk("fair_count", 32'(ngr), 6);
    bus.req = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk("fair_drain", 32'({bus.busy, bus.rsp_valid}), 0);

    // Asynchronous reset while CAPTURE holds an overflowing result
    bus.req   = 4'b0001;
    bus.req_a = 16'h000F;
    bus.req_b = 16'h0001;
    tick();
    bus.req = 4'b0000;
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp_ovf_cnt = 0;
    check_reset_state("arst");
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("arst_silent", 32'({bus.ack, bus.rsp_valid, bus.busy}), 0);
      tick();
    end
    rv = '{4'b0010, 16'h0050, 16'h0030, 1, 4'h8, 1'b0};
    run_txn(rv, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
